// File: rtl/tournament_predictor_param.sv
`default_nettype none
// ============================================================================
// Module   : tournament_predictor_param
// Brief    : Parametrised gshare + two-level local tournament predictor for
//            conditional BR, with non-speculative GHR and perf counters.
// Revision : 1.0
// ============================================================================
module tournament_predictor_param #(
    parameter int PC_WIDTH     = 16,
    parameter int GHR_BITS     = 8,
    parameter int LHT_IDX_BITS = 6,
    parameter int LHR_BITS     = 6,
    parameter int CHS_IDX_BITS = 6,
    parameter int CTR_BITS     = 2,
    parameter int PERF_BITS    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic                 pred_global,
    output logic                 pred_local,
    output logic [GHR_BITS-1:0]  pred_ghr,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic                 upd_global,
    input  logic                 upd_local,
    input  logic [GHR_BITS-1:0]  upd_ghr,
    input  logic                 upd_pred_taken,
    output logic [PERF_BITS-1:0] perf_branches,
    output logic [PERF_BITS-1:0] perf_mispredicts
);

    localparam int c_gpht_n = 1 << GHR_BITS;
    localparam int c_lht_n  = 1 << LHT_IDX_BITS;
    localparam int c_lpht_n = 1 << LHR_BITS;
    localparam int c_chs_n  = 1 << CHS_IDX_BITS;
    localparam int c_ext_w  = PC_WIDTH + GHR_BITS + LHT_IDX_BITS + CHS_IDX_BITS;
    localparam logic [CTR_BITS-1:0] c_ctr_init = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] gpht_q [0:c_gpht_n-1];
    logic [CTR_BITS-1:0] lpht_q [0:c_lpht_n-1];
    logic [CTR_BITS-1:0] chs_q  [0:c_chs_n-1];
    logic [LHR_BITS-1:0] lht_q  [0:c_lht_n-1];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic                pred_global_q, pred_global_d;
    logic                pred_local_q, pred_local_d;
    logic [GHR_BITS-1:0] pred_ghr_q, pred_ghr_d;
    logic [PERF_BITS-1:0] perf_br_q, perf_br_d;
    logic [PERF_BITS-1:0] perf_mis_q, perf_mis_d;

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                     input logic up);
        if (up) return (c == '1) ? c : c + CTR_BITS'(1);
        else    return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    // Zero-extended PCs so every index slice stays in range for any PC_WIDTH.
    logic [c_ext_w-1:0]      w_lk_pc_ext, w_up_pc_ext;
    logic [GHR_BITS-1:0]     w_lk_gidx, w_up_gidx;
    logic [LHT_IDX_BITS-1:0] w_lk_lht, w_up_lht;
    logic [LHR_BITS-1:0]     w_lk_lidx, w_up_lidx;
    logic [CHS_IDX_BITS-1:0] w_lk_cidx, w_up_cidx;
    logic [CTR_BITS-1:0]     w_gpht_new, w_lpht_new, w_chs_new;
    logic [LHR_BITS-1:0]     w_lht_new;
    logic                    w_g_ok, w_l_ok;
    logic                    w_unused_pc_bits;

    assign w_lk_pc_ext = c_ext_w'(lookup_pc);
    assign w_up_pc_ext = c_ext_w'(upd_pc);
    assign w_unused_pc_bits = ^{w_lk_pc_ext, w_up_pc_ext};

    assign w_lk_gidx = w_lk_pc_ext[GHR_BITS:1] ^ ghr_q;
    assign w_lk_lht  = w_lk_pc_ext[LHT_IDX_BITS:1];
    assign w_lk_lidx = lht_q[w_lk_lht];
    assign w_lk_cidx = w_lk_pc_ext[CHS_IDX_BITS:1];

    assign w_up_gidx = w_up_pc_ext[GHR_BITS:1] ^ upd_ghr;
    assign w_up_lht  = w_up_pc_ext[LHT_IDX_BITS:1];
    assign w_up_lidx = lht_q[w_up_lht];
    assign w_up_cidx = w_up_pc_ext[CHS_IDX_BITS:1];

    assign w_g_ok = (upd_global == upd_taken);
    assign w_l_ok = (upd_local == upd_taken);

    always_comb begin
        w_gpht_new = sat_step(gpht_q[w_up_gidx], upd_taken);
        w_lpht_new = sat_step(lpht_q[w_up_lidx], upd_taken);
        w_lht_new  = LHR_BITS'({w_up_lidx, upd_taken});
        w_chs_new  = chs_q[w_up_cidx];
        if (w_g_ok && !w_l_ok)      w_chs_new = sat_step(chs_q[w_up_cidx], 1'b1);
        else if (!w_g_ok && w_l_ok) w_chs_new = sat_step(chs_q[w_up_cidx], 1'b0);
    end

    always_comb begin
        pred_valid_d  = lookup_valid;
        pred_global_d = pred_global_q;
        pred_local_d  = pred_local_q;
        pred_taken_d  = pred_taken_q;
        pred_ghr_d    = pred_ghr_q;
        if (lookup_valid) begin
            pred_global_d = gpht_q[w_lk_gidx][CTR_BITS-1];
            pred_local_d  = lpht_q[w_lk_lidx][CTR_BITS-1];
            pred_taken_d  = chs_q[w_lk_cidx][CTR_BITS-1] ? pred_global_d : pred_local_d;
            pred_ghr_d    = ghr_q;
        end
        ghr_d      = ghr_q;
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (upd_valid) begin
            // GHR is rebuilt from the carried snapshot, so wrong-path lookups never pollute it.
            ghr_d     = GHR_BITS'({upd_ghr, upd_taken});
            perf_br_d = perf_br_q + PERF_BITS'(1);
            if (upd_pred_taken != upd_taken) perf_mis_d = perf_mis_q + PERF_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_gpht_n; i++) gpht_q[i] <= c_ctr_init;
            for (int i = 0; i < c_lpht_n; i++) lpht_q[i] <= c_ctr_init;
            for (int i = 0; i < c_chs_n; i++)  chs_q[i]  <= c_ctr_init;
            for (int i = 0; i < c_lht_n; i++)  lht_q[i]  <= '0;
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_global_q <= 1'b0;
            pred_local_q  <= 1'b0;
            pred_ghr_q    <= '0;
            perf_br_q     <= '0;
            perf_mis_q    <= '0;
        end else begin
            if (upd_valid) begin
                gpht_q[w_up_gidx] <= w_gpht_new;
                lpht_q[w_up_lidx] <= w_lpht_new;
                lht_q[w_up_lht]   <= w_lht_new;
                chs_q[w_up_cidx]  <= w_chs_new;
            end
            ghr_q         <= ghr_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_global_q <= pred_global_d;
            pred_local_q  <= pred_local_d;
            pred_ghr_q    <= pred_ghr_d;
            perf_br_q     <= perf_br_d;
            perf_mis_q    <= perf_mis_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_global      = pred_global_q;
    assign pred_local       = pred_local_q;
    assign pred_ghr         = pred_ghr_q;
    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;

endmodule
`default_nettype wire

// File: doc/tournament_predictor_param.md
Name: tournament_predictor_param

Overview:
Parametrised tournament predictor for conditional BR in the lc3b pipeline, replacing the fixed single-chooser design. It has a gshare global PHT, a two-level local predictor (local history table plus local PHT) and a per-PC chooser table. All table sizes and counter widths are parameters. IF sends a lookup and receives a registered prediction one cycle later; WB sends the resolved outcome plus the lookup metadata back for training. The block also keeps saturating-free performance counters.

Parameters:
PC_WIDTH, 16, width of lookup/update PC (bit 0 ignored; word-aligned)
GHR_BITS, 8, global history length; global PHT has 2^GHR_BITS entries
LHT_IDX_BITS, 6, local history table index bits (2^LHT_IDX_BITS entries)
LHR_BITS, 6, local history length; local PHT has 2^LHR_BITS entries
CHS_IDX_BITS, 6, chooser table index bits
CTR_BITS, 2, width of every PHT and chooser counter (>=2)
PERF_BITS, 32, width of performance counters

Ports:
clk  in  1  clock (only clock)
rst  in  1  synchronous, active-high reset
lookup_valid  in  1  IF presents a conditional BR for prediction
lookup_pc  in  PC_WIDTH  PC of that BR
pred_valid  out  1  prediction valid (1 cycle after lookup_valid)
pred_taken  out  1  final prediction
pred_global  out  1  global component prediction
pred_local  out  1  local component prediction
pred_ghr  out  GHR_BITS  GHR snapshot used for the global index
upd_valid  in  1  WB resolves a conditional BR
upd_pc  in  PC_WIDTH  PC of the resolved BR
upd_taken  in  1  actual outcome
upd_global  in  1  pred_global carried down the pipe
upd_local  in  1  pred_local carried down the pipe
upd_ghr  in  GHR_BITS  pred_ghr carried down the pipe
upd_pred_taken  in  1  pred_taken carried down the pipe
perf_branches  out  PERF_BITS  resolved-branch count
perf_mispredicts  out  PERF_BITS  mispredict count

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - every PHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken);
  - every chooser counter = 2^(CTR_BITS-1)-1 (weakly local; MSB 0 = local, 1 = global);
  - GHR = 0; all local histories = 0;
  - pred_* outputs = 0; perf counters = 0.
- Index functions:
  - gidx = lookup_pc[GHR_BITS:1] ^ GHR;
  - lht_idx = pc[LHT_IDX_BITS:1]; lidx = LHT[lht_idx];
  - cidx = pc[CHS_IDX_BITS:1].
  - PC bits above each index width are dropped. If PC_WIDTH-1 < index width, the PC is zero-extended.
- Lookup (latency 1):
  - At the edge where lookup_valid=1, register: pred_global = gPHT[gidx] MSB; pred_local = lPHT[lidx] MSB; pred_ghr = GHR.
  - pred_taken = chooser[cidx] MSB ? pred_global : pred_local.
  - pred_valid is 1 for exactly that following cycle and 0 otherwise. pred_* values hold when pred_valid=0.
- Update (at the edge where upd_valid=1):
  - gPHT[upd_pc[GHR_BITS:1]^upd_ghr]: +1 if taken, -1 if not, saturating at 0 and 2^CTR_BITS-1.
  - lPHT[LHT[upd lht_idx]]: same saturating rule.
  - LHT[upd lht_idx] = {hist[LHR_BITS-2:0], upd_taken}.
  - GHR = {upd_ghr[GHR_BITS-2:0], upd_taken}. Non-speculative: the GHR is repaired from the carried snapshot.
  - chooser[cidx]: +1 (saturating) if upd_global==upd_taken and upd_local!=upd_taken; -1 (saturating) in the reverse case; unchanged if both components were right or both wrong.
  - perf_branches += 1. perf_mispredicts += 1 if upd_pred_taken != upd_taken. Both wrap modulo 2^PERF_BITS.
- Simultaneous lookup and update in the same cycle: the lookup reads pre-update state for all tables and the GHR (no bypass). The update still commits at that edge.
- Back-to-back lookups are allowed every cycle; no stall or handshake beyond the valid signals.
- rst asserted mid-operation: all state returns to reset values at that edge. A lookup presented in that cycle produces no pred_valid. An update presented in that cycle is discarded.
- Only conditional BR goes through this block. JMP/JSR/TRAP prediction and flush generation stay in the pipeline/BTB logic.

Test Plan:
- Reset: assert rst, then a lookup at PC 0x3000 -> one cycle later pred_valid=1, pred_taken=0, pred_global=0, pred_local=0, pred_ghr=0; both perf counters = 0.
- Saturation (CTR_BITS=2): 5 taken updates at PC 0x3010 -> gPHT entry reaches 3 and stays at 3. Then 1 not-taken update -> entry = 2; a lookup still predicts taken.
- Chooser training: 2 updates at PC 0x3020 with upd_global=1, upd_local=0, upd_taken=1 -> chooser goes 1->2->3; the next lookup selects global (pred_taken = pred_global).
- Local pattern: 40 updates at PC 0x3040 alternating T/N (LHR_BITS=6) -> afterwards the local prediction matches the alternation on 10 of 10 further lookups.
- Same-cycle conflict: lookup and taken update to the same gPHT entry (counter value 1) in one cycle -> prediction uses old value 1 (not-taken); the counter becomes 2 after the edge.
- Perf and reset mid-run: 10 updates, 3 of them mispredicted -> perf 10/3. Assert rst together with upd_valid -> counters read 0 and no pred_valid in the following cycle.
